// File: rtl/freq_counter_mc.sv
// -----------------------------------------------------------------------------
// freq_counter_mc
//
// Multi-channel gated frequency counter. Every test input and the GPS 1 PPS
// reference are synchronised into the fastclk domain and reduced to one-cycle
// rising-edge strobes. Edges of each channel are accumulated over a gate of
// 1..(2^GATE_W-1) PPS periods. At gate close one saturating count per channel
// is published together with sticky overflow flags and a wrapping sequence
// number. Loss of PPS drops lock and discards the partial gate.
//
// Parameters
//   CHANNELS    : number of test inputs (1..8)
//   CNT_W       : count width per channel
//   GATE_W      : width of gate_secs
//   PPS_TIMEOUT : fastclk cycles without a PPS edge before lock is dropped
//
// Ports
//   fastclk      in  : sole clock, rising edge
//   rst          in  : synchronous active-high reset
//   test_in      in  : asynchronous signals to measure, bit i = channel i
//   gps_pps      in  : asynchronous 1 PPS gate reference
//   gate_secs    in  : gate length in PPS periods (0 behaves as 1)
//   count_out    out : latched counts, channel i at [i*CNT_W +: CNT_W]
//   ovf_out      out : per-channel overflow flag of the latched gate
//   result_valid out : one-cycle pulse when the latched outputs update
//   gate_seq     out : completed-gate counter, wraps 255 -> 0
//   pps_locked   out : high while PPS edges arrive within PPS_TIMEOUT
// -----------------------------------------------------------------------------
module freq_counter_mc #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 4,
  parameter int PPS_TIMEOUT = 150000000
) (
  input  logic                      fastclk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       test_in,
  input  logic                      gps_pps,
  input  logic [GATE_W-1:0]         gate_secs,
  output logic [CHANNELS*CNT_W-1:0] count_out,
  output logic [CHANNELS-1:0]       ovf_out,
  output logic                      result_valid,
  output logic [7:0]                gate_seq,
  output logic                      pps_locked
);

  localparam int                NIN       = CHANNELS + 1;
  localparam int                TMO_W     = $clog2(PPS_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(PPS_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    S_IDLE,
    S_COUNT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning. PPS rides as the top bit of the same vector as the test
  // inputs so every input sees exactly the same pipeline latency (pad -> strobe
  // is 3 cycles) and the gate boundaries line up with the channel edges.
  // ---------------------------------------------------------------------------
  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] r_meta;
  logic [NIN-1:0] r_sync;
  logic [NIN-1:0] r_prev;
  logic [NIN-1:0] r_edge;

  assign w_raw = {gps_pps, test_in};

  always_ff @(posedge fastclk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_edge <= r_sync & ~r_prev;
    end
  end

  logic [CHANNELS-1:0] w_ch_edge;
  logic                w_pps_edge;

  assign w_ch_edge  = r_edge[CHANNELS-1:0];
  assign w_pps_edge = r_edge[CHANNELS];

  // ---------------------------------------------------------------------------
  // Gate state
  // ---------------------------------------------------------------------------
  state_t                             r_state, r_state_next;
  logic [CHANNELS-1:0][CNT_W-1:0]     r_acc, r_acc_next;
  logic [CHANNELS-1:0]                r_ovf_acc, r_ovf_acc_next;
  logic [GATE_W-1:0]                  r_sec, r_sec_next;
  logic [GATE_W-1:0]                  r_target, r_target_next;
  logic [TMO_W-1:0]                   r_tmo, r_tmo_next;
  logic [CHANNELS-1:0][CNT_W-1:0]     r_count, r_count_next;
  logic [CHANNELS-1:0]                r_ovf, r_ovf_next;
  logic                               r_valid, r_valid_next;
  logic [7:0]                         r_seq, r_seq_next;
  logic                               r_locked, r_locked_next;

  // Accumulator value including this cycle's strobe; used both for normal
  // counting and as the gate result so a strobe coincident with the closing
  // PPS strobe is credited to the closing gate.
  logic [CHANNELS-1:0][CNT_W-1:0]     w_acc_inc;
  logic [CHANNELS-1:0]                w_ovf_inc;
  logic [CHANNELS-1:0]                w_acc_sat;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_acc_sat[gi] = (r_acc[gi] == CNT_MAX);
      assign w_acc_inc[gi] = (w_ch_edge[gi] && !w_acc_sat[gi]) ?
                             r_acc[gi] + CNT_W'(1) : r_acc[gi];
      assign w_ovf_inc[gi] = r_ovf_acc[gi] | (w_ch_edge[gi] & w_acc_sat[gi]);
    end
  endgenerate

  logic [GATE_W-1:0] w_gate_load;
  logic [GATE_W-1:0] w_sec_inc;
  logic [TMO_W-1:0]  w_tmo_inc;

  assign w_gate_load = (gate_secs == '0) ? GATE_W'(1) : gate_secs;
  assign w_sec_inc   = r_sec + GATE_W'(1);
  assign w_tmo_inc   = r_tmo + TMO_W'(1);

  always_comb begin
    r_state_next   = r_state;
    r_acc_next     = r_acc;
    r_ovf_acc_next = r_ovf_acc;
    r_sec_next     = r_sec;
    r_target_next  = r_target;
    r_tmo_next     = r_tmo;
    r_count_next   = r_count;
    r_ovf_next     = r_ovf;
    r_valid_next   = 1'b0;
    r_seq_next     = r_seq;
    r_locked_next  = r_locked;

    case (r_state)
      S_IDLE: begin
        r_acc_next     = '0;
        r_ovf_acc_next = '0;
        r_locked_next  = 1'b0;
        if (w_pps_edge) begin
          r_state_next  = S_COUNT;
          r_locked_next = 1'b1;
          r_target_next = w_gate_load;
          r_sec_next    = '0;
          r_tmo_next    = '0;
        end
      end

      S_COUNT: begin
        r_acc_next     = w_acc_inc;
        r_ovf_acc_next = w_ovf_inc;
        r_tmo_next     = w_tmo_inc;
        // A PPS strobe takes priority over a coincident timeout.
        if (w_pps_edge) begin
          r_tmo_next = '0;
          r_sec_next = w_sec_inc;
          if (w_sec_inc == r_target) begin
            r_count_next   = w_acc_inc;
            r_ovf_next     = w_ovf_inc;
            r_seq_next     = r_seq + 8'd1;
            r_valid_next   = 1'b1;
            r_acc_next     = '0;
            r_ovf_acc_next = '0;
            r_sec_next     = '0;
            r_target_next  = w_gate_load;
          end
        end else if (w_tmo_inc == TMO_LIMIT) begin
          // Partial gate is discarded; latched outputs are left untouched.
          r_state_next   = S_IDLE;
          r_locked_next  = 1'b0;
          r_acc_next     = '0;
          r_ovf_acc_next = '0;
          r_tmo_next     = '0;
        end
      end

      default: begin
        r_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_ovf_acc <= '0;
      r_sec     <= '0;
      r_target  <= '0;
      r_tmo     <= '0;
      r_count   <= '0;
      r_ovf     <= '0;
      r_valid   <= 1'b0;
      r_seq     <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_acc     <= r_acc_next;
      r_ovf_acc <= r_ovf_acc_next;
      r_sec     <= r_sec_next;
      r_target  <= r_target_next;
      r_tmo     <= r_tmo_next;
      r_count   <= r_count_next;
      r_ovf     <= r_ovf_next;
      r_valid   <= r_valid_next;
      r_seq     <= r_seq_next;
      r_locked  <= r_locked_next;
    end
  end

  assign count_out    = r_count;
  assign ovf_out      = r_ovf;
  assign result_valid = r_valid;
  assign gate_seq     = r_seq;
  assign pps_locked   = r_locked;

endmodule

// File: tb/tb_freq_counter_mc.sv
// -----------------------------------------------------------------------------
// tb_freq_counter_mc
//
// Directed bench for freq_counter_mc. Two instances share one stimulus: a
// 32-bit-count instance for exact counts and an 8-bit-count instance for the
// saturation/overflow behaviour. The pad waveforms are derived from one
// free-running cycle index so every channel rising edge that falls on a PPS
// second is sampled in the same cycle as the PPS edge.
// -----------------------------------------------------------------------------
module tb_freq_counter_mc;

  logic        fastclk = 1'b0;
  logic        rst;
  logic [1:0]  test_in;
  logic        gps_pps;
  logic [3:0]  gate_secs;

  logic [63:0] cnt_a;
  logic [1:0]  ovf_a;
  logic        valid_a;
  logic [7:0]  seq_a;
  logic        lock_a;

  logic [15:0] cnt_b;
  logic [1:0]  ovf_b;
  logic        valid_b;
  logic [7:0]  seq_b;
  logic        lock_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_valid  = 0;
  int t_lock   = 0;
  int t_prev   = 0;

  // stimulus generator controls
  int p0      = 4;
  int p1      = 10;
  int pps_per = 1000;
  bit pps_en  = 1'b0;
  bit en_eff  = 1'b0;
  int t       = 0;

  always #5 fastclk = ~fastclk;

  always @(posedge fastclk) cyc <= cyc + 1;

  freq_counter_mc #(
    .CHANNELS(2), .CNT_W(32), .GATE_W(4), .PPS_TIMEOUT(3000)
  ) dut_a (
    .fastclk(fastclk), .rst(rst), .test_in(test_in), .gps_pps(gps_pps),
    .gate_secs(gate_secs), .count_out(cnt_a), .ovf_out(ovf_a),
    .result_valid(valid_a), .gate_seq(seq_a), .pps_locked(lock_a)
  );

  freq_counter_mc #(
    .CHANNELS(2), .CNT_W(8), .GATE_W(4), .PPS_TIMEOUT(3000)
  ) dut_b (
    .fastclk(fastclk), .rst(rst), .test_in(test_in), .gps_pps(gps_pps),
    .gate_secs(gate_secs), .count_out(cnt_b), .ovf_out(ovf_b),
    .result_valid(valid_b), .gate_seq(seq_b), .pps_locked(lock_b)
  );

  // Pad waveforms: channel i rises whenever t is a multiple of its period, PPS
  // rises on multiples of pps_per. PPS enable only changes on a second
  // boundary so no short or misaligned PPS pulse is ever produced.
  initial begin : stim_gen
    test_in = 2'b00;
    gps_pps = 1'b0;
    forever begin
      @(posedge fastclk);
      #1;
      t++;
      if ((t % pps_per) == 0) en_eff = pps_en;
      gps_pps    = en_eff && ((t % pps_per) < 10);
      test_in[0] = (t % p0) < (p0 / 2);
      test_in[1] = (t % p1) < (p1 / 2);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge fastclk);
      k++;
    end while (!valid_a && k < max_cyc);
    chk(tag, valid_a, 1'b1);
    t_valid = cyc;
  endtask

  task automatic wait_lock(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge fastclk);
      k++;
    end while (!lock_a && k < max_cyc);
    chk(tag, lock_a, 1'b1);
    t_lock = cyc;
  endtask

  initial begin : main
    int seen;
    rst       = 1'b1;
    gate_secs = 4'd1;
    repeat (4) @(negedge fastclk);

    // reset state
    chk("rst_count_a", cnt_a, 64'd0);
    chk("rst_count_b", cnt_b, 64'd0);
    chk("rst_ovf_a",   ovf_a, 64'd0);
    chk("rst_valid",   {valid_a, valid_b}, 64'd0);
    chk("rst_seq",     seq_a, 64'd0);
    chk("rst_locked",  {lock_a, lock_b}, 64'd0);
    $display("txn reset: count=%0d seq=%0d locked=%0d", cnt_a, seq_a, lock_a);

    rst    = 1'b0;
    pps_en = 1'b1;

    // basic count, first gate after lock
    wait_lock("g1_lock", 2500);
    wait_valid("g1_valid", 1500);
    chk("g1_ch0", cnt_a[31:0], 64'd250);
    chk("g1_ch1", cnt_a[63:32], 64'd100);
    chk("g1_ovf", ovf_a, 64'd0);
    chk("g1_seq", seq_a, 64'd1);
    chk("g1_latency", t_valid - t_lock, 64'd1000);
    chk("g1_b_ch0", cnt_b[7:0], 64'd250);
    chk("g1_b_ovf", ovf_b, 64'd0);
    $display("txn gate1: ch0=%0d ch1=%0d seq=%0d", cnt_a[31:0], cnt_a[63:32], seq_a);
    t_prev = t_valid;
    @(negedge fastclk);
    chk("g1_pulse_width", valid_a, 1'b0);

    wait_valid("g2_valid", 1500);
    chk("g2_ch0", cnt_a[31:0], 64'd250);
    chk("g2_ch1", cnt_a[63:32], 64'd100);
    chk("g2_seq", seq_a, 64'd2);
    chk("g2_interval", t_valid - t_prev, 64'd1000);
    $display("txn gate2: ch0=%0d ch1=%0d seq=%0d", cnt_a[31:0], cnt_a[63:32], seq_a);
    t_prev = t_valid;

    // long gate; change lands only on the gate after the one in progress
    gate_secs = 4'd3;
    wait_valid("g3_valid", 1500);
    chk("g3_ch0", cnt_a[31:0], 64'd250);
    chk("g3_seq", seq_a, 64'd3);
    chk("g3_interval", t_valid - t_prev, 64'd1000);
    $display("txn gate3: ch0=%0d seq=%0d", cnt_a[31:0], seq_a);
    t_prev = t_valid;

    wait_valid("g4_valid", 3500);
    chk("g4_ch0", cnt_a[31:0], 64'd750);
    chk("g4_ch1", cnt_a[63:32], 64'd300);
    chk("g4_seq", seq_a, 64'd4);
    chk("g4_interval", t_valid - t_prev, 64'd3000);
    chk("g4_b_count", cnt_b, 64'hFFFF);
    chk("g4_b_ovf", ovf_b, 64'd3);
    $display("txn gate4: ch0=%0d ch1=%0d seq=%0d b_ovf=%0d", cnt_a[31:0], cnt_a[63:32], seq_a, ovf_b);
    t_prev = t_valid;

    // gate_secs = 0 behaves as 1, again from the following gate
    gate_secs = 4'd0;
    wait_valid("g5_valid", 3500);
    chk("g5_ch0", cnt_a[31:0], 64'd750);
    chk("g5_interval", t_valid - t_prev, 64'd3000);
    $display("txn gate5: ch0=%0d seq=%0d", cnt_a[31:0], seq_a);
    t_prev = t_valid;

    wait_valid("g6_valid", 1500);
    chk("g6_ch0", cnt_a[31:0], 64'd250);
    chk("g6_seq", seq_a, 64'd6);
    chk("g6_interval", t_valid - t_prev, 64'd1000);
    chk("g6_b_ovf", ovf_b, 64'd0);
    $display("txn gate6: ch0=%0d seq=%0d", cnt_a[31:0], seq_a);

    // overflow on the 8-bit instance
    p0 = 2;
    wait_valid("g7_valid", 1500);
    chk("g7_b_ch0", cnt_b[7:0], 64'd255);
    chk("g7_b_ovf", ovf_b, 64'd1);
    $display("txn gate7: b_ch0=%0d b_ovf=%0d", cnt_b[7:0], ovf_b);

    wait_valid("g8_valid", 1500);
    chk("g8_ch0", cnt_a[31:0], 64'd500);
    chk("g8_ovf", ovf_a, 64'd0);
    chk("g8_b_ch0", cnt_b[7:0], 64'd255);
    chk("g8_b_ch1", cnt_b[15:8], 64'd100);
    chk("g8_b_ovf", ovf_b, 64'd1);
    $display("txn gate8: ch0=%0d b_ch0=%0d b_ovf=%0d", cnt_a[31:0], cnt_b[7:0], ovf_b);

    p0 = 10;
    wait_valid("g9_valid", 1500);
    chk("g9_b_ovf", ovf_b, 64'd0);
    $display("txn gate9: b_ovf=%0d seq=%0d", ovf_b, seq_a);

    wait_valid("g10_valid", 1500);
    chk("g10_ch0", cnt_a[31:0], 64'd100);
    chk("g10_b_ch0", cnt_b[7:0], 64'd100);
    chk("g10_b_ovf", ovf_b, 64'd0);
    chk("g10_seq", seq_a, 64'd10);
    $display("txn gate10: ch0=%0d b_ch0=%0d seq=%0d", cnt_a[31:0], cnt_b[7:0], seq_a);

    // PPS loss: lock drops exactly 3000 quiet cycles after the last strobe
    p0     = 4;
    pps_en = 1'b0;
    seen   = 0;
    for (int i = 0; i < 2999; i++) begin
      @(negedge fastclk);
      if (valid_a) seen++;
    end
    chk("loss_lock_before", lock_a, 1'b1);
    @(negedge fastclk);
    chk("loss_lock_after", lock_a, 1'b0);
    chk("loss_no_valid", seen, 64'd0);
    chk("loss_seq_hold", seq_a, 64'd10);
    chk("loss_count_hold", cnt_a, {32'd100, 32'd100});
    $display("txn pps_loss: locked=%0d seq=%0d ch0=%0d", lock_a, seq_a, cnt_a[31:0]);

    // relock: first result one full gate after the relock edge
    pps_en = 1'b1;
    wait_lock("relock", 2500);
    wait_valid("g11_valid", 1500);
    chk("g11_ch0", cnt_a[31:0], 64'd250);
    chk("g11_ch1", cnt_a[63:32], 64'd100);
    chk("g11_seq", seq_a, 64'd11);
    chk("g11_latency", t_valid - t_lock, 64'd1000);
    $display("txn gate11: ch0=%0d ch1=%0d seq=%0d", cnt_a[31:0], cnt_a[63:32], seq_a);

    // reset mid-gate
    repeat (300) @(negedge fastclk);
    rst = 1'b1;
    @(negedge fastclk);
    rst = 1'b0;
    chk("mrst_count", cnt_a, 64'd0);
    chk("mrst_ovf", ovf_b, 64'd0);
    chk("mrst_seq", seq_a, 64'd0);
    chk("mrst_locked", lock_a, 1'b0);
    $display("txn mid_reset: count=%0d seq=%0d locked=%0d", cnt_a, seq_a, lock_a);
    wait_lock("mrst_lock", 2500);
    wait_valid("mrst_valid", 1500);
    chk("mrst_ch0", cnt_a[31:0], 64'd250);
    chk("mrst_seq1", seq_a, 64'd1);
    chk("mrst_latency", t_valid - t_lock, 64'd1000);
    $display("txn gate_after_reset: ch0=%0d seq=%0d", cnt_a[31:0], seq_a);

    // sequence wrap with a short PPS period
    pps_per = 40;
    for (int i = 0; i < 300; i++) begin
      wait_valid("wrap_step", 200);
      if (seq_a == 8'd255) break;
    end
    chk("wrap_reach_255", seq_a, 64'd255);
    t_prev = t_valid;
    wait_valid("wrap_valid", 200);
    chk("wrap_seq", seq_a, 64'd0);
    chk("wrap_seq_b", seq_b, 64'd0);
    chk("wrap_ch0", cnt_a[31:0], 64'd10);
    chk("wrap_ch1", cnt_a[63:32], 64'd4);
    chk("wrap_interval", t_valid - t_prev, 64'd40);
    $display("txn seq_wrap: seq=%0d ch0=%0d ch1=%0d", seq_a, cnt_a[31:0], cnt_a[63:32]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
